// File: rtl/mtpu_pkg.sv
// mtpu_pkg: shared defaults, sequencer states and saturation helper for the systolic engine.
package mtpu_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 16;
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, DRAIN, DONE} state_e;
    // Returns {clamp_max, clamp_min} from operand/sum MSBs; unsigned overflow shows up as the carry.
    function automatic logic [1:0] sat_sel(input logic sm, input logic sa, input logic sb,
                                           input logic ss, input logic carry);
        return sm ? {~sa & ~sb & ss, sa & sb & ~ss} : {carry, 1'b0};
    endfunction
endpackage

// File: rtl/mm_pe.sv
// mm_pe: one processing element - forwards operands and tags, saturating signed/unsigned MAC.
module mm_pe
    import mtpu_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  sm_i,
    input  logic                  va_i,
    input  logic                  vb_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  va_o,
    output logic                  vb_o,
    output logic [DATA_WIDTH-1:0] a_o,
    output logic [DATA_WIDTH-1:0] b_o,
    output logic [ACC_WIDTH-1:0]  acc_o
);
    localparam int PW = 2 * DATA_WIDTH;
    logic signed [PW-1:0]  prod_s;
    logic [PW-1:0]         prod_u;
    logic [ACC_WIDTH-1:0]  prod_x, smax, smin, acc_q, acc_d;
    logic [ACC_WIDTH:0]    sum;
    logic [1:0]            sel;
    logic                  va_q, vb_q;
    logic [DATA_WIDTH-1:0] a_q, b_q;

    always_comb begin
        prod_s = PW'($signed(a_i)) * PW'($signed(b_i));
        prod_u = PW'(a_i) * PW'(b_i);
        prod_x = sm_i ? ACC_WIDTH'(prod_s) : ACC_WIDTH'(prod_u);
        sum    = {1'b0, acc_q} + {1'b0, prod_x};
        sel    = sat_sel(sm_i, acc_q[ACC_WIDTH-1], prod_x[ACC_WIDTH-1], sum[ACC_WIDTH-1], sum[ACC_WIDTH]);
        smax   = sm_i ? {1'b0, {(ACC_WIDTH-1){1'b1}}} : '1;
        smin   = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        acc_d  = clr_i ? '0 : !(va_i && vb_i) ? acc_q : sel[1] ? smax : sel[0] ? smin : sum[ACC_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            va_q  <= 1'b0;
            vb_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            a_q   <= a_i;
            b_q   <= b_i;
            va_q  <= va_i;
            vb_q  <= vb_i;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign va_o  = va_q;
    assign vb_o  = vb_q;
    assign acc_o = acc_q;
endmodule

// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine: output-stationary ROWS x COLS systolic matrix multiplier with
// internal operand skew, valid tags and a start/load/drain sequencer.
module systolic_mm_engine
    import mtpu_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int KLEN_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [KLEN_WIDTH-1:0]          k_len,
    input  logic                           signed_mode,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0]     a_in,
    input  logic [COLS*DATA_WIDTH-1:0]     b_in,
    output logic                           busy,
    output logic                           done,
    output logic                           result_valid,
    output logic [ROWS*COLS*ACC_WIDTH-1:0] c_out
);
    localparam int DW  = DATA_WIDTH;
    localparam int AW  = ACC_WIDTH;
    localparam int DCW = $clog2(ROWS + COLS);

    state_e                state_q, state_d;
    logic [KLEN_WIDTH-1:0] klen_q, klen_d, beat_q, beat_d;
    logic [DCW-1:0]        drn_q, drn_d;
    logic                  sm_q, sm_d, rv_q, rv_d, clr, acc;

    always_comb begin
        state_d  = state_q;
        klen_d   = klen_q;
        sm_d     = sm_q;
        beat_d   = beat_q;
        drn_d    = drn_q;
        rv_d     = rv_q;
        clr      = 1'b0;
        in_ready = state_q == LOAD;
        busy     = state_q inside {CLEAR, LOAD, DRAIN};
        done     = state_q == DONE;
        acc      = in_valid & in_ready;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    klen_d  = k_len;
                    sm_d    = signed_mode;
                end
            end
            CLEAR: begin
                clr     = 1'b1;
                rv_d    = 1'b0;
                beat_d  = '0;
                drn_d   = '0;
                state_d = klen_q != '0 ? LOAD : DONE;
            end
            LOAD: begin
                if (acc) begin
                    beat_d = beat_q + KLEN_WIDTH'(1);
                    if (beat_q == klen_q - KLEN_WIDTH'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                drn_d = drn_q + DCW'(1);
                if (drn_q == DCW'(ROWS + COLS - 2)) state_d = DONE;
            end
            default: begin
                rv_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            klen_q  <= '0;
            sm_q    <= 1'b0;
            beat_q  <= '0;
            drn_q   <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            sm_q    <= sm_d;
            beat_q  <= beat_d;
            drn_q   <= drn_d;
            rv_q    <= rv_d;
        end
    end

    assign result_valid = rv_q;

    // Column 0 of a_h and row 0 of b_v carry the skewed edge inputs; the rest are PE forwards.
    logic [DW-1:0] a_h  [ROWS][COLS+1];
    logic          va_h [ROWS][COLS+1];
    logic [DW-1:0] b_v  [ROWS+1][COLS];
    logic          vb_v [ROWS+1][COLS];

    for (genvar r = 0; r < ROWS; r++) begin : g_ska
        if (r == 0) begin : g_dir
            assign a_h[r][0]  = a_in[r*DW +: DW];
            assign va_h[r][0] = acc;
        end else begin : g_dly
            logic [r*DW-1:0] d_q;
            logic [r-1:0]    v_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d_q <= '0;
                    v_q <= '0;
                end else begin
                    d_q <= (r*DW)'({d_q, a_in[r*DW +: DW]});
                    v_q <= (r)'({v_q, acc});
                end
            end
            assign a_h[r][0]  = d_q[r*DW-1 -: DW];
            assign va_h[r][0] = v_q[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_skb
        if (c == 0) begin : g_dir
            assign b_v[0][c]  = b_in[c*DW +: DW];
            assign vb_v[0][c] = acc;
        end else begin : g_dly
            logic [c*DW-1:0] d_q;
            logic [c-1:0]    v_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d_q <= '0;
                    v_q <= '0;
                end else begin
                    d_q <= (c*DW)'({d_q, b_in[c*DW +: DW]});
                    v_q <= (c)'({v_q, acc});
                end
            end
            assign b_v[0][c]  = d_q[c*DW-1 -: DW];
            assign vb_v[0][c] = v_q[c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            mm_pe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) u_pe (
                .clk   (clk),
                .rst_n (rst_n),
                .clr_i (clr),
                .sm_i  (sm_q),
                .va_i  (va_h[r][c]),
                .vb_i  (vb_v[r][c]),
                .a_i   (a_h[r][c]),
                .b_i   (b_v[r][c]),
                .va_o  (va_h[r][c+1]),
                .vb_o  (vb_v[r+1][c]),
                .a_o   (a_h[r][c+1]),
                .b_o   (b_v[r+1][c]),
                .acc_o (c_out[(r*COLS+c)*AW +: AW])
            );
        end
    end
endmodule
